usb2_endp_router: RTL and testbench
===================================

Name: usb2_endp_router

Overview:
Parametrised successor to the fixed 4-endpoint mux in the USB 2.0 protocol layer. Routes the packet-layer buffer interface to NUM_EP endpoint buffer ports. Adds per-transaction latching of the endpoint select, centralised per-endpoint data toggles and halt (STALL) bits, a mode table parameter, and an arm/ack handshake with timeout. Sits between usb2_packet and the usb2_ep0/usb2_ep instances, replacing the combinational select logic.

Parameters:
NUM_EP, 4, number of endpoints (1..16); index 0 is always control
EP_MODES, 8'b01_10_10_00, packed 2 bits per endpoint, ep i at [2i+1:2i]: 0 control, 1 isoch, 2 bulk, 3 interrupt
ADDR_W, 11, buffer address width
LEN_W, 11, length width
ARM_TIMEOUT, 255, phy_clk cycles to wait for an endpoint arm_ack (max 65535)

Ports:
phy_clk  in  1  clock
reset  in  1  synchronous, active-high
sel_endp  in  4  endpoint number from the token
sel_valid  in  1  pulse: transaction start, samples sel_endp
sel_done  in  1  pulse: transaction end
buf_in_addr/data/wren/commit/commit_len  in  ADDR_W/8/1/1/LEN_W  packet-to-endpoint write side
buf_in_ready, buf_in_commit_ack  out  1,1  from the selected endpoint
buf_out_addr  in  ADDR_W  read address
buf_out_q, buf_out_len, buf_out_hasdata  out  8/LEN_W/1  from the selected endpoint
buf_out_arm  in  1  pulse: request arm
buf_out_arm_ack  out  1  one-cycle pulse
arm_timeout  out  1  one-cycle pulse
endp_mode  out  2  mode of the latched endpoint
data_toggle_act  in  1  pulse: advance toggle
data_toggle  out  2  PID sequence for the latched endpoint
endp_invalid  out  1  high while the latched endpoint is out of range or halted
halt_set, halt_clr, toggle_clr  in  1,1,1  pulses from ep0 request decoding
ctl_endp  in  4  target endpoint for halt_set/halt_clr/toggle_clr
ep_buf_in_addr/data/wren/commit/commit_len  out  NUM_EP×(ADDR_W/8/1/1/LEN_W)  flattened fan-out
ep_buf_in_ready, ep_buf_in_commit_ack  in  NUM_EP  per-endpoint status
ep_buf_out_addr  out  NUM_EP×ADDR_W  per-endpoint read address
ep_buf_out_q, ep_buf_out_len, ep_buf_out_hasdata  in  NUM_EP×(8/LEN_W/1)  per-endpoint read data
ep_buf_out_arm  out  NUM_EP  level, held until ack or abort
ep_buf_out_arm_ack  in  NUM_EP  per-endpoint ack
stat_sel  in  4  statistics endpoint select
stat_q  out  16  statistics readback

Behaviour:
- States: ST_IDLE, ST_ACTIVE, ST_ARM_WAIT, ST_ERR. Reset → ST_IDLE, latched sel = 0, all toggles 0, all halts 0. All outputs 0; endp_mode = 0.
- ST_IDLE on sel_valid: latch sel_endp.
  - If sel_endp ≥ NUM_EP, or sel_endp ≠ 0 and its halt bit is set: go to ST_ERR.
  - Otherwise: go to ST_ACTIVE.
- ST_IDLE: every ep_* output is 0. Every packet-side return (ready, q, len, hasdata, commit_ack) is 0.
- ST_ACTIVE: combinational routing using the latched sel. Non-selected ep_* outputs are forced to 0. Returns come from the selected endpoint.
- buf_out_arm in ST_ACTIVE: assert ep_buf_out_arm[sel], clear the counter, go to ST_ARM_WAIT.
- ST_ARM_WAIT: counter increments each cycle.
  - ep_buf_out_arm_ack[sel]: drop arm, pulse buf_out_arm_ack the next cycle, return to ST_ACTIVE.
  - Counter reaches ARM_TIMEOUT: drop arm, pulse arm_timeout, return to ST_ACTIVE.
  - If ack arrives on the same cycle as timeout, ack wins.
- sel_done in ST_ACTIVE, ST_ARM_WAIT or ST_ERR → ST_IDLE next cycle. In ST_ARM_WAIT, arm drops with no ack pulse.
- sel_valid outside ST_IDLE is ignored.
- ST_ERR: endp_invalid = 1; all routing is blocked; data_toggle_act is ignored.
- Toggles: 1 bit per endpoint.
  - data_toggle_act in ST_ACTIVE/ST_ARM_WAIT flips the bit for the latched endpoint, unless its mode is isoch.
  - data_toggle = {1'b0, bit}. Isoch endpoints always read 2'b00.
- toggle_clr clears the toggle of ctl_endp. halt_set sets its halt bit and also clears its toggle. halt_clr clears its halt bit. ctl_endp ≥ NUM_EP is ignored. Endpoint 0 halt is never stored.
- If a control pulse and data_toggle_act hit the same endpoint in the same cycle, the control pulse wins.
- A halt_set on the latched endpoint mid-transaction does not abort the transaction; it takes effect at the next sel_valid.
- reset mid-operation: immediate return to ST_IDLE; arm drops; all per-endpoint state is cleared.

Optional Feature:
USB2_EP_STATS_EN: per-endpoint 16-bit saturating counters, cleared by reset.
- Increment on each buf_out_arm_ack pulse or buf_in_commit_ack rising edge for the latched endpoint.
- stat_q = counter[stat_sel]; 0 if stat_sel ≥ NUM_EP.
- Without the macro: stat_q is tied to 0 and no counters are built.

Test Plan:
- Reset, then sel_valid with sel_endp=1 and EP1 hasdata=1, len=512 → ST_ACTIVE; buf_out_len=512; EP0/2/3 addr and arm read 0.
- sel_endp=5 with NUM_EP=4 → endp_invalid=1, buf_in_ready=0, data_toggle_act has no effect; sel_done → endp_invalid=0.
- EP2 bulk: three data_toggle_act pulses → data_toggle 1,0,1. EP3 isoch: two pulses → stays 2'b00. toggle_clr with ctl_endp=2 → EP2 toggle 0.
- buf_out_arm on EP1 with ack after 10 cycles → buf_out_arm_ack pulses once. No ack with ARM_TIMEOUT=20 → arm_timeout pulse at cycle 20 and arm drops.
- halt_set with ctl_endp=1, then sel_valid with sel_endp=1 → ST_ERR. halt_clr with ctl_endp=1, then sel_valid → ST_ACTIVE with toggle 0. halt_set with ctl_endp=0 → EP0 stays usable.
- With USB2_EP_STATS_EN: 3 arm acks on EP1 → stat_q=3 for stat_sel=1. Reset asserted during ST_ARM_WAIT → arm drops the next cycle and stat_q=0.

Source files
------------

// File: rtl/usb2_endp_router.sv
// Routes the packet-layer buffer interface to one of NUM_EP endpoint ports and owns the
// per-endpoint data toggles, halt bits and arm handshake. Define USB2_EP_STATS_EN for ack counters.
module usb2_endp_router #(
    parameter int unsigned         NUM_EP      = 4,
    parameter logic [2*NUM_EP-1:0] EP_MODES    = 8'b01_10_10_00,
    parameter int unsigned         ADDR_W      = 11,
    parameter int unsigned         LEN_W       = 11,
    parameter int unsigned         ARM_TIMEOUT = 255
) (
    input  logic                      phy_clk,
    input  logic                      reset,
    input  logic [3:0]                sel_endp,
    input  logic                      sel_valid,
    input  logic                      sel_done,
    input  logic [ADDR_W-1:0]         buf_in_addr,
    input  logic [7:0]                buf_in_data,
    input  logic                      buf_in_wren,
    input  logic                      buf_in_commit,
    input  logic [LEN_W-1:0]          buf_in_commit_len,
    output logic                      buf_in_ready,
    output logic                      buf_in_commit_ack,
    input  logic [ADDR_W-1:0]         buf_out_addr,
    output logic [7:0]                buf_out_q,
    output logic [LEN_W-1:0]          buf_out_len,
    output logic                      buf_out_hasdata,
    input  logic                      buf_out_arm,
    output logic                      buf_out_arm_ack,
    output logic                      arm_timeout,
    output logic [1:0]                endp_mode,
    input  logic                      data_toggle_act,
    output logic [1:0]                data_toggle,
    output logic                      endp_invalid,
    input  logic                      halt_set,
    input  logic                      halt_clr,
    input  logic                      toggle_clr,
    input  logic [3:0]                ctl_endp,
    output logic [NUM_EP*ADDR_W-1:0]  ep_buf_in_addr,
    output logic [NUM_EP*8-1:0]       ep_buf_in_data,
    output logic [NUM_EP-1:0]         ep_buf_in_wren,
    output logic [NUM_EP-1:0]         ep_buf_in_commit,
    output logic [NUM_EP*LEN_W-1:0]   ep_buf_in_commit_len,
    input  logic [NUM_EP-1:0]         ep_buf_in_ready,
    input  logic [NUM_EP-1:0]         ep_buf_in_commit_ack,
    output logic [NUM_EP*ADDR_W-1:0]  ep_buf_out_addr,
    input  logic [NUM_EP*8-1:0]       ep_buf_out_q,
    input  logic [NUM_EP*LEN_W-1:0]   ep_buf_out_len,
    input  logic [NUM_EP-1:0]         ep_buf_out_hasdata,
    output logic [NUM_EP-1:0]         ep_buf_out_arm,
    input  logic [NUM_EP-1:0]         ep_buf_out_arm_ack,
    input  logic [3:0]                stat_sel,
    output logic [15:0]               stat_q
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_ARM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR      = 2'd3;
    localparam logic [1:0] MODE_ISOCH  = 2'd1;

    logic [1:0]        state, state_next;
    logic [3:0]        sel, sel_next;
    logic [15:0]       cnt, cnt_next;
    logic              ack_pulse, ack_pulse_next;
    logic              tmo_pulse, tmo_pulse_next;
    logic [NUM_EP-1:0] toggle, halt;
    logic              routing, req_in_range, req_halted, ctl_in_range, sel_arm_ack;

    assign routing       = (state == ST_ACTIVE) || (state == ST_ARM_WAIT);
    assign req_in_range  = {1'b0, sel_endp} < 5'(NUM_EP);
    assign ctl_in_range  = {1'b0, ctl_endp} < 5'(NUM_EP);
    assign endp_invalid  = (state == ST_ERR);
    assign buf_out_arm_ack = ack_pulse;
    assign arm_timeout     = tmo_pulse;

    always_comb begin
        req_halted = 1'b0;
        for (int i = 0; i < int'(NUM_EP); i++) begin
            if (sel_endp == 4'(i)) req_halted = halt[i];
        end
    end

    // Next-state logic; sel_done always beats a pending arm ack or timeout
    always_comb begin
        state_next     = state;
        sel_next       = sel;
        cnt_next       = cnt;
        ack_pulse_next = 1'b0;
        tmo_pulse_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    sel_next   = sel_endp;
                    state_next = (!req_in_range || (sel_endp != 4'd0 && req_halted)) ? ST_ERR : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (sel_done) begin
                    state_next = ST_IDLE;
                end else if (buf_out_arm) begin
                    cnt_next   = 16'd0;
                    state_next = ST_ARM_WAIT;
                end
            end
            ST_ARM_WAIT: begin
                if (sel_done) begin
                    state_next = ST_IDLE;
                end else if (sel_arm_ack) begin
                    state_next     = ST_ACTIVE;
                    ack_pulse_next = 1'b1;
                end else if (cnt >= 16'(ARM_TIMEOUT - 1)) begin
                    state_next     = ST_ACTIVE;
                    tmo_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            ST_ERR: begin
                if (sel_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel       <= 4'd0;
            cnt       <= 16'd0;
            ack_pulse <= 1'b0;
            tmo_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            cnt       <= cnt_next;
            ack_pulse <= ack_pulse_next;
            tmo_pulse <= tmo_pulse_next;
        end
    end

    // Fan-out to the latched endpoint only; everything else reads zero
    always_comb begin
        ep_buf_in_addr       = '0;
        ep_buf_in_data       = '0;
        ep_buf_in_wren       = '0;
        ep_buf_in_commit     = '0;
        ep_buf_in_commit_len = '0;
        ep_buf_out_addr      = '0;
        ep_buf_out_arm       = '0;
        buf_in_ready         = 1'b0;
        buf_in_commit_ack    = 1'b0;
        buf_out_q            = 8'd0;
        buf_out_len          = '0;
        buf_out_hasdata      = 1'b0;
        sel_arm_ack          = 1'b0;
        endp_mode            = 2'd0;
        data_toggle          = 2'd0;
        for (int i = 0; i < int'(NUM_EP); i++) begin
            if (sel == 4'(i)) begin
                endp_mode   = EP_MODES[2*i +: 2];
                data_toggle = (EP_MODES[2*i +: 2] == MODE_ISOCH) ? 2'd0 : {1'b0, toggle[i]};
                sel_arm_ack = ep_buf_out_arm_ack[i];
                ep_buf_out_arm[i] = (state == ST_ARM_WAIT);
                if (routing) begin
                    ep_buf_in_addr[i*ADDR_W +: ADDR_W]     = buf_in_addr;
                    ep_buf_in_data[i*8 +: 8]               = buf_in_data;
                    ep_buf_in_wren[i]                      = buf_in_wren;
                    ep_buf_in_commit[i]                    = buf_in_commit;
                    ep_buf_in_commit_len[i*LEN_W +: LEN_W] = buf_in_commit_len;
                    ep_buf_out_addr[i*ADDR_W +: ADDR_W]    = buf_out_addr;
                    buf_in_ready      = ep_buf_in_ready[i];
                    buf_in_commit_ack = ep_buf_in_commit_ack[i];
                    buf_out_q         = ep_buf_out_q[i*8 +: 8];
                    buf_out_len       = ep_buf_out_len[i*LEN_W +: LEN_W];
                    buf_out_hasdata   = ep_buf_out_hasdata[i];
                end
            end
        end
    end

    // Toggle and halt bits; a control pulse overrides a same-cycle toggle advance
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            toggle <= '0;
            halt   <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_EP); i++) begin
                if (ctl_in_range && ctl_endp == 4'(i) && (toggle_clr || halt_set)) begin
                    toggle[i] <= 1'b0;
                end else if (data_toggle_act && routing && sel == 4'(i) &&
                             EP_MODES[2*i +: 2] != MODE_ISOCH) begin
                    toggle[i] <= ~toggle[i];
                end
                if (i != 0 && ctl_in_range && ctl_endp == 4'(i)) begin
                    if (halt_set)      halt[i] <= 1'b1;
                    else if (halt_clr) halt[i] <= 1'b0;
                end
            end
        end
    end

`ifdef USB2_EP_STATS_EN
    logic        commit_ack_d;
    logic [1:0]  stat_inc;
    logic [15:0] stat_cnt [NUM_EP];

    assign stat_inc = 2'(ack_pulse) + 2'(buf_in_commit_ack & ~commit_ack_d);

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            commit_ack_d <= 1'b0;
            for (int i = 0; i < int'(NUM_EP); i++) stat_cnt[i] <= 16'd0;
        end else begin
            commit_ack_d <= buf_in_commit_ack;
            for (int i = 0; i < int'(NUM_EP); i++) begin
                if (sel == 4'(i) && stat_inc != 2'd0) begin
                    stat_cnt[i] <= (({1'b0, stat_cnt[i]} + 17'(stat_inc)) > 17'h0FFFF) ?
                                   16'hFFFF : stat_cnt[i] + 16'(stat_inc);
                end
            end
        end
    end

    always_comb begin
        stat_q = 16'd0;
        for (int i = 0; i < int'(NUM_EP); i++) begin
            if (stat_sel == 4'(i)) stat_q = stat_cnt[i];
        end
    end
`else
    logic unused_stat;
    assign unused_stat = ^stat_sel;
    assign stat_q      = 16'd0;
`endif

endmodule

// File: tb/tb_usb2_endp_router.sv
// Scoreboard bench for usb2_endp_router: stimulus queues expected values, a negedge monitor compares.
module tb_usb2_endp_router;
    localparam int NUM_EP = 4;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 11;
    localparam int TMO    = 20;

    localparam int F_INV = 0, F_RDY = 1, F_LEN = 2, F_HAS = 3, F_TOG = 4, F_MODE = 5;
    localparam int F_ARM = 6, F_Q = 7, F_STAT = 8, F_OADDR = 9;
    localparam int EV_ACK = 0, EV_TMO = 1;

    typedef struct { int f; int idx; logic [31:0] exp_val; string name; } snap_t;
    typedef struct { int kind; int cyc; } ev_t;

    logic phy_clk = 1'b0;
    logic reset;
    logic [3:0] sel_endp, ctl_endp, stat_sel;
    logic sel_valid, sel_done, buf_in_wren, buf_in_commit, buf_out_arm, data_toggle_act;
    logic halt_set, halt_clr, toggle_clr;
    logic [ADDR_W-1:0] buf_in_addr, buf_out_addr;
    logic [7:0] buf_in_data, buf_out_q;
    logic [LEN_W-1:0] buf_in_commit_len, buf_out_len;
    logic buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack, arm_timeout, endp_invalid;
    logic [1:0] endp_mode, data_toggle;
    logic [15:0] stat_q;
    logic [NUM_EP*ADDR_W-1:0] ep_buf_in_addr, ep_buf_out_addr;
    logic [NUM_EP*8-1:0] ep_buf_in_data, ep_buf_out_q;
    logic [NUM_EP*LEN_W-1:0] ep_buf_in_commit_len, ep_buf_out_len;
    logic [NUM_EP-1:0] ep_buf_in_wren, ep_buf_in_commit, ep_buf_in_ready, ep_buf_in_commit_ack;
    logic [NUM_EP-1:0] ep_buf_out_hasdata, ep_buf_out_arm, ep_buf_out_arm_ack;

    usb2_endp_router #(.NUM_EP(NUM_EP), .EP_MODES(8'b01_10_10_00), .ADDR_W(ADDR_W),
                       .LEN_W(LEN_W), .ARM_TIMEOUT(TMO)) dut (
        .phy_clk(phy_clk), .reset(reset), .sel_endp(sel_endp), .sel_valid(sel_valid),
        .sel_done(sel_done), .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
        .buf_in_wren(buf_in_wren), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_ready(buf_in_ready),
        .buf_in_commit_ack(buf_in_commit_ack), .buf_out_addr(buf_out_addr),
        .buf_out_q(buf_out_q), .buf_out_len(buf_out_len), .buf_out_hasdata(buf_out_hasdata),
        .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack), .arm_timeout(arm_timeout),
        .endp_mode(endp_mode), .data_toggle_act(data_toggle_act), .data_toggle(data_toggle),
        .endp_invalid(endp_invalid), .halt_set(halt_set), .halt_clr(halt_clr),
        .toggle_clr(toggle_clr), .ctl_endp(ctl_endp), .ep_buf_in_addr(ep_buf_in_addr),
        .ep_buf_in_data(ep_buf_in_data), .ep_buf_in_wren(ep_buf_in_wren),
        .ep_buf_in_commit(ep_buf_in_commit), .ep_buf_in_commit_len(ep_buf_in_commit_len),
        .ep_buf_in_ready(ep_buf_in_ready), .ep_buf_in_commit_ack(ep_buf_in_commit_ack),
        .ep_buf_out_addr(ep_buf_out_addr), .ep_buf_out_q(ep_buf_out_q),
        .ep_buf_out_len(ep_buf_out_len), .ep_buf_out_hasdata(ep_buf_out_hasdata),
        .ep_buf_out_arm(ep_buf_out_arm), .ep_buf_out_arm_ack(ep_buf_out_arm_ack),
        .stat_sel(stat_sel), .stat_q(stat_q)
    );

    always #5 phy_clk = ~phy_clk;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  snap_go = 1'b0;
    logic  end_go = 1'b0;
    snap_t snq[$];
    ev_t   evq[$];

    always @(posedge phy_clk) cyc <= cyc + 1;

    function automatic logic [31:0] field(input int f, input int idx);
        case (f)
            F_INV:   return 32'(endp_invalid);
            F_RDY:   return 32'(buf_in_ready);
            F_LEN:   return 32'(buf_out_len);
            F_HAS:   return 32'(buf_out_hasdata);
            F_TOG:   return 32'(data_toggle);
            F_MODE:  return 32'(endp_mode);
            F_ARM:   return 32'(ep_buf_out_arm);
            F_Q:     return 32'(buf_out_q);
            F_STAT:  return 32'(stat_q);
            F_OADDR: return 32'(ep_buf_out_addr[idx*ADDR_W +: ADDR_W]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops pulse events as the DUT emits them and drains snapshot expectations
    always @(negedge phy_clk) begin
        if (buf_out_arm_ack || arm_timeout) begin
            n_cmp++;
            if (evq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got ack=%0b tmo=%0b at cycle %0d, required no event",
                         buf_out_arm_ack, arm_timeout, cyc);
            end else begin
                ev_t e;
                e = evq.pop_front();
                if (buf_out_arm_ack == arm_timeout || e.kind != (buf_out_arm_ack ? EV_ACK : EV_TMO)
                    || e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL arm_event: got ack=%0b tmo=%0b at cycle %0d, required kind %0d at cycle %0d",
                             buf_out_arm_ack, arm_timeout, cyc, e.kind, e.cyc);
                end
            end
        end
        if (snap_go) begin
            while (snq.size() > 0) begin
                snap_t s;
                logic [31:0] got;
                s = snq.pop_front();
                got = field(s.f, s.idx);
                n_cmp++;
                if (got !== s.exp_val) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, required %0h", s.name, got, s.exp_val);
                end
            end
        end
        if (end_go) begin
            n_cmp++;
            if (evq.size() != 0) begin
                n_bad++;
                $display("FAIL missing_events: got %0d still pending, required 0", evq.size());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic want(input string name, input int f, input int idx, input logic [31:0] v);
        snap_t s;
        s.f = f; s.idx = idx; s.exp_val = v; s.name = name;
        snq.push_back(s);
    endtask

    task automatic check();
        snap_go = 1'b1;
        @(negedge phy_clk);
        #1;
        snap_go = 1'b0;
    endtask

    task automatic select(input logic [3:0] e);
        sel_endp = e; sel_valid = 1'b1; tick(); sel_valid = 1'b0;
    endtask

    task automatic done();
        sel_done = 1'b1; tick(); sel_done = 1'b0;
    endtask

    task automatic act();
        data_toggle_act = 1'b1; tick(); data_toggle_act = 1'b0;
    endtask

    task automatic ctl(input logic hs, input logic hc, input logic tc, input logic [3:0] e);
        ctl_endp = e; halt_set = hs; halt_clr = hc; toggle_clr = tc;
        tick();
        halt_set = 1'b0; halt_clr = 1'b0; toggle_clr = 1'b0;
    endtask

    task automatic arm_pulse(output int c);
        buf_out_arm = 1'b1; c = cyc; tick(); buf_out_arm = 1'b0;
    endtask

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind; e.cyc = c;
        evq.push_back(e);
    endtask

    initial begin
        int c;
        reset = 1'b1; sel_endp = 4'd0; sel_valid = 1'b0; sel_done = 1'b0; ctl_endp = 4'd0;
        halt_set = 1'b0; halt_clr = 1'b0; toggle_clr = 1'b0; data_toggle_act = 1'b0;
        buf_out_arm = 1'b0; stat_sel = 4'd1;
        buf_in_addr = 11'h123; buf_in_data = 8'h55; buf_in_wren = 1'b0; buf_in_commit = 1'b0;
        buf_in_commit_len = 11'd0; buf_out_addr = 11'h2AA;
        ep_buf_out_len = {11'd100, 11'd64, 11'd512, 11'd8};
        ep_buf_out_q = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ep_buf_out_hasdata = 4'b0010; ep_buf_in_ready = 4'b1010;
        ep_buf_in_commit_ack = 4'b0000; ep_buf_out_arm_ack = 4'b0000;
        repeat (3) tick();
        want("rst_inv", F_INV, 0, 0); want("rst_rdy", F_RDY, 0, 0); want("rst_len", F_LEN, 0, 0);
        want("rst_tog", F_TOG, 0, 0); want("rst_mode", F_MODE, 0, 0); want("rst_arm", F_ARM, 0, 0);
        want("rst_stat", F_STAT, 0, 0);
        check();
        reset = 1'b0; tick();

        // EP1 routing
        select(4'd1);
        want("ep1_len", F_LEN, 0, 512); want("ep1_has", F_HAS, 0, 1); want("ep1_rdy", F_RDY, 0, 1);
        want("ep1_q", F_Q, 0, 32'hA1); want("ep1_mode", F_MODE, 0, 2); want("ep1_inv", F_INV, 0, 0);
        want("ep1_oaddr", F_OADDR, 1, 32'h2AA); want("ep0_oaddr", F_OADDR, 0, 0);
        want("ep2_oaddr", F_OADDR, 2, 0); want("ep3_oaddr", F_OADDR, 3, 0);
        want("ep1_arm_idle", F_ARM, 0, 0);
        check();
        done();
        want("idle_len", F_LEN, 0, 0); want("idle_oaddr1", F_OADDR, 1, 0);
        check();

        // Out-of-range endpoint
        select(4'd5);
        want("oor_inv", F_INV, 0, 1); want("oor_rdy", F_RDY, 0, 0); want("oor_len", F_LEN, 0, 0);
        check();
        act();
        want("oor_tog", F_TOG, 0, 0);
        check();
        done();
        want("oor_done_inv", F_INV, 0, 0);
        check();

        // Toggles: EP2 bulk, EP3 isoch
        select(4'd2);
        act(); want("ep2_tog1", F_TOG, 0, 1); check();
        act(); want("ep2_tog2", F_TOG, 0, 0); check();
        act(); want("ep2_tog3", F_TOG, 0, 1); check();
        done();
        select(4'd3);
        act(); act();
        want("ep3_tog", F_TOG, 0, 0); want("ep3_mode", F_MODE, 0, 1);
        check();
        done();
        ctl(1'b0, 1'b0, 1'b1, 4'd2);
        select(4'd2);
        want("ep2_togclr", F_TOG, 0, 0);
        check();
        done();

        // Arm with ack after 10 cycles
        select(4'd1);
        arm_pulse(c);
        push_ev(EV_ACK, c + 11);
        want("arm_level", F_ARM, 0, 32'b0010); check();
        repeat (9) tick();
        ep_buf_out_arm_ack[1] = 1'b1; tick(); ep_buf_out_arm_ack[1] = 1'b0;
        want("arm_drop_ack", F_ARM, 0, 0); check();

        // Arm without ack: timeout after TMO cycles
        arm_pulse(c);
        push_ev(EV_TMO, c + 1 + TMO);
        repeat (17) tick();
        want("arm_late", F_ARM, 0, 32'b0010); check();
        repeat (4) tick();
        want("arm_drop_tmo", F_ARM, 0, 0); check();

        // sel_done aborts the wait silently
        arm_pulse(c);
        repeat (3) tick();
        done();
        want("abort_arm", F_ARM, 0, 0); want("abort_len", F_LEN, 0, 0);
        check();
        repeat (3) tick();

        // Halt handling
        select(4'd1); act(); done();
        ctl(1'b1, 1'b0, 1'b0, 4'd1);
        select(4'd1);
        want("halt_inv", F_INV, 0, 1); want("halt_rdy", F_RDY, 0, 0);
        check();
        done();
        ctl(1'b0, 1'b1, 1'b0, 4'd1);
        select(4'd1);
        want("unhalt_inv", F_INV, 0, 0); want("unhalt_tog", F_TOG, 0, 0); want("unhalt_rdy", F_RDY, 0, 1);
        check();
        done();
        ctl(1'b1, 1'b0, 1'b0, 4'd0);
        select(4'd0);
        want("ep0_inv", F_INV, 0, 0); want("ep0_len", F_LEN, 0, 8);
        check();
        done();
        select(4'd2);
        ctl(1'b1, 1'b0, 1'b0, 4'd2);
        want("midhalt_inv", F_INV, 0, 0); check();
        done();
        select(4'd2);
        want("nexthalt_inv", F_INV, 0, 1); check();
        done();
        ctl(1'b0, 1'b1, 1'b0, 4'd2);

        // Control pulse beats a same-cycle toggle advance
        select(4'd2);
        ctl_endp = 4'd2; toggle_clr = 1'b1; data_toggle_act = 1'b1;
        tick();
        toggle_clr = 1'b0; data_toggle_act = 1'b0;
        want("ctl_wins", F_TOG, 0, 0); check();
        act();
        want("post_ctl_tog", F_TOG, 0, 1); check();
        done();
        ctl(1'b1, 1'b0, 1'b0, 4'd3);

`ifdef USB2_EP_STATS_EN
        select(4'd1);
        for (int k = 0; k < 3; k++) begin
            arm_pulse(c);
            push_ev(EV_ACK, c + 2);
            ep_buf_out_arm_ack[1] = 1'b1; tick(); ep_buf_out_arm_ack[1] = 1'b0;
            tick();
        end
        stat_sel = 4'd1;
        want("stat_acks", F_STAT, 0, 3); check();
        ep_buf_in_commit_ack = 4'b0010; repeat (2) tick(); ep_buf_in_commit_ack = 4'b0000; tick();
        want("stat_commit", F_STAT, 0, 4); check();
        stat_sel = 4'd5;
        want("stat_oor", F_STAT, 0, 0); check();
        stat_sel = 4'd1;
        done();
`else
        want("stat_off", F_STAT, 0, 0); check();
`endif

        // Reset during arm wait clears everything
        select(4'd1);
        arm_pulse(c);
        tick();
        reset = 1'b1; tick();
        want("rst_arm_drop", F_ARM, 0, 0); want("rst_stat0", F_STAT, 0, 0);
        check();
        reset = 1'b0; tick();
        select(4'd2);
        want("rst_tog_clr", F_TOG, 0, 0); check();
        done();
        select(4'd3);
        want("rst_halt_clr", F_INV, 0, 0); check();
        done();
        repeat (2) tick();

        end_go = 1'b1;
        @(negedge phy_clk);
        #1;
        end_go = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
